// File: rtl/alu_precond16_if.sv
// Handshake bundle between the raw-operand producer, the preconditioning
// stage and the downstream ALU core.
interface alu_precond16_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] xp;
    logic [WIDTH-1:0] yp;
    logic             f_q;
    logic             no_q;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
        input  in_ready, out_valid, xp, yp, f_q, no_q
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
        output in_ready, out_valid, xp, yp, f_q, no_q
    );
endinterface

// File: rtl/alu_precond16.sv
// Hack ALU operand preconditioning (zero then invert) registered behind a
// two-entry skid buffer so the stage sustains one set per cycle.
module alu_precond16 #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    alu_precond16_if.slave bus
);
    localparam int DW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    occ_e          state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic [DW-1:0] s_data_q, s_data_d;
    logic [DW-1:0] pre_s;
    logic          acc_s;
    logic          drn_s;

    function automatic logic [WIDTH-1:0] precond(input logic [WIDTH-1:0] v,
                                                 input logic zero,
                                                 input logic inv);
        logic [WIDTH-1:0] t;
        t = zero ? {WIDTH{1'b0}} : v;
        return inv ? ~t : t;
    endfunction

    // Preconditioned payload and handshake events for the coming edge.
    always_comb begin
        pre_s = {precond(bus.x, bus.zx, bus.nx),
                 precond(bus.y, bus.zy, bus.ny),
                 bus.f, bus.no};
        acc_s = bus.in_valid && in_ready_q;
        drn_s = out_valid_q && bus.out_ready;
    end

    // Occupancy next-state and register steering.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc_s) begin
                    m_data_d = pre_s;
                    state_d  = ST_ONE;
                end else begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (acc_s && drn_s) begin
                    m_data_d = pre_s;
                    state_d  = ST_ONE;
                end else if (acc_s) begin
                    // Main is stalled, so the new set parks in the skid slot.
                    s_data_d = pre_s;
                    state_d  = ST_FULL;
                end else if (drn_s) begin
                    state_d  = ST_EMPTY;
                end else begin
                    state_d  = ST_ONE;
                end
            end
            ST_FULL: begin
                if (drn_s) begin
                    m_data_d = s_data_q;
                    state_d  = ST_ONE;
                end else begin
                    state_d  = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_data_q    <= {DW{1'b0}};
            s_data_q    <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            m_data_q    <= m_data_d;
            s_data_q    <= s_data_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.xp        = m_data_q[DW-1:WIDTH+2];
    assign bus.yp        = m_data_q[WIDTH+1:2];
    assign bus.f_q       = m_data_q[1];
    assign bus.no_q      = m_data_q[0];
endmodule

// File: tb/tb_alu_precond16.sv
// Directed and randomized bench for alu_precond16 against a queue-based
// FIFO model whose entries follow the zero/invert rules arithmetically.
module tb_alu_precond16;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_precond16_if #(.WIDTH(W)) bus ();
    alu_precond16 #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    logic [33:0] sb[$];

    function automatic logic [33:0] ref_model(input logic [15:0] x,
                                              input logic [15:0] y,
                                              input logic [5:0] ctl);
        int unsigned xs;
        int unsigned ys;
        logic [15:0] xo;
        logic [15:0] yo;
        xs = ctl[5] ? 0 : int'(x);
        if (ctl[4]) xs = 65535 - xs;
        ys = ctl[3] ? 0 : int'(y);
        if (ctl[2]) ys = 65535 - ys;
        xo = xs[15:0];
        yo = ys[15:0];
        return {xo, yo, ctl[1], ctl[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() > 0});
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, sb.size() < 2});
        if (sb.size() > 0) begin
            chk("xp", {16'd0, bus.xp}, {16'd0, sb[0][33:18]});
            chk("yp", {16'd0, bus.yp}, {16'd0, sb[0][17:2]});
            chk("f_q", {31'd0, bus.f_q}, {31'd0, sb[0][1]});
            chk("no_q", {31'd0, bus.no_q}, {31'd0, sb[0][0]});
        end
    endtask

    task automatic drive_cycle(input logic iv, input logic [15:0] ix, input logic [15:0] iy,
                               input logic [5:0] ctl, input logic ordy, input logic rst);
        logic acc;
        logic drn;
        bus.in_valid  = iv;
        bus.x         = ix;
        bus.y         = iy;
        bus.zx        = ctl[5];
        bus.nx        = ctl[4];
        bus.zy        = ctl[3];
        bus.ny        = ctl[2];
        bus.f         = ctl[1];
        bus.no        = ctl[0];
        bus.out_ready = ordy;
        reset         = rst;
        acc = iv && !rst && (sb.size() < 2);
        drn = ordy && !rst && (sb.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
        end else begin
            if (drn) sb.delete(0);
            if (acc) sb.push_back(ref_model(ix, iy, ctl));
        end
        check_model();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ov"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_ir"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_xp"}, {16'd0, bus.xp}, 32'd0);
        chk({tag, "_yp"}, {16'd0, bus.yp}, 32'd0);
        chk({tag, "_f"}, {31'd0, bus.f_q}, 32'd0);
        chk({tag, "_no"}, {31'd0, bus.no_q}, 32'd0);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            drive_cycle(1'b0, 16'h0000, 16'h0000, 6'd0, 1'b1, 1'b0);
            guard++;
        end
        chk(tag, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] r3;
        logic        exp_ir;

        bus.in_valid = 1'b0; bus.x = 16'h0000; bus.y = 16'h0000;
        bus.zx = 1'b0; bus.nx = 1'b0; bus.zy = 1'b0; bus.ny = 1'b0;
        bus.f = 1'b0; bus.no = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b1;

        drive_cycle(1'b0, 16'h0000, 16'h0000, 6'd0, 1'b0, 1'b1);
        drive_cycle(1'b0, 16'h0000, 16'h0000, 6'd0, 1'b0, 1'b1);
        check_reset_state("reset");

        // in_valid together with reset must not be captured
        drive_cycle(1'b1, 16'hAAAA, 16'h5555, 6'b000011, 1'b0, 1'b1);
        chk("rst_acc_ov", {31'd0, bus.out_valid}, 32'd0);
        drive_cycle(1'b0, 16'h0000, 16'h0000, 6'd0, 1'b0, 1'b0);
        chk("rst_acc_ov2", {31'd0, bus.out_valid}, 32'd0);

        drive_cycle(1'b1, 16'h00FF, 16'h1234, 6'b011110, 1'b0, 1'b0);
        chk("t1_ov", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_xp", {16'd0, bus.xp}, 32'h0000FF00);
        chk("t1_yp", {16'd0, bus.yp}, 32'h0000FFFF);
        chk("t1_f", {31'd0, bus.f_q}, 32'd1);
        chk("t1_no", {31'd0, bus.no_q}, 32'd0);

        drive_cycle(1'b1, 16'h0005, 16'h0000, 6'b011111, 1'b1, 1'b0);
        chk("xp1_xp", {16'd0, bus.xp}, 32'h0000FFFA);
        chk("xp1_yp", {16'd0, bus.yp}, 32'h0000FFFF);
        chk("xp1_no", {31'd0, bus.no_q}, 32'd1);

        drive_cycle(1'b1, 16'hBEEF, 16'h1111, 6'b100000, 1'b1, 1'b0);
        chk("zx_xp", {16'd0, bus.xp}, 32'h00000000);
        chk("zx_yp", {16'd0, bus.yp}, 32'h00001111);
        drain("drain1");

        // backpressure: A then B fill the stage, C is refused
        drive_cycle(1'b1, 16'h1234, 16'h0F0F, 6'b000000, 1'b0, 1'b0);
        drive_cycle(1'b1, 16'h4321, 16'h0F0F, 6'b000100, 1'b0, 1'b0);
        chk("bp_ir", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_xpA", {16'd0, bus.xp}, 32'h00001234);
        drive_cycle(1'b1, 16'h7777, 16'h7777, 6'b000000, 1'b0, 1'b0);
        chk("bp_hold", {16'd0, bus.xp}, 32'h00001234);
        drive_cycle(1'b0, 16'h0000, 16'h0000, 6'd0, 1'b1, 1'b0);
        chk("bp_xpB", {16'd0, bus.xp}, 32'h00004321);
        chk("bp_ypB", {16'd0, bus.yp}, 32'h0000F0F0);
        chk("bp_ir2", {31'd0, bus.in_ready}, 32'd1);
        drive_cycle(1'b0, 16'h0000, 16'h0000, 6'd0, 1'b1, 1'b0);
        chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        for (int i = 0; i < 64; i++) begin
            r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
            drive_cycle(1'b1, r1[15:0], r2[15:0], r3[5:0], 1'b1, 1'b0);
            chk("stream_ov", {31'd0, bus.out_valid}, 32'd1);
        end
        drain("drain2");

        for (int i = 0; i < 1000; i++) begin
            r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
            // toggling out_ready mid-cycle must not move in_ready
            exp_ir = (sb.size() < 2);
            bus.out_ready = ~bus.out_ready;
            #1;
            chk("ir_comb", {31'd0, bus.in_ready}, {31'd0, exp_ir});
            drive_cycle(r3[8], r1[15:0], r2[15:0], r3[5:0], r3[9] | r3[10], 1'b0);
        end
        drain("drain3");

        drive_cycle(1'b1, 16'hCAFE, 16'hF00D, 6'b010111, 1'b0, 1'b0);
        drive_cycle(1'b1, 16'hDEAD, 16'hBEEF, 6'b000110, 1'b0, 1'b0);
        chk("full_ir", {31'd0, bus.in_ready}, 32'd0);
        drive_cycle(1'b1, 16'h1357, 16'h2468, 6'b000011, 1'b1, 1'b1);
        check_reset_state("rstfull");
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 16'h0000, 16'h0000, 6'd0, 1'b1, 1'b0);
            chk("rstfull_gone", {31'd0, bus.out_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
